// File: rtl/csr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// csr_ctrl_pkg : shared encodings for the CSR read-modify-write controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package csr_ctrl_pkg;

    localparam logic [2:0] CSR_OP_RW  = 3'b001;
    localparam logic [2:0] CSR_OP_RS  = 3'b010;
    localparam logic [2:0] CSR_OP_RC  = 3'b011;
    localparam logic [2:0] CSR_OP_RWI = 3'b101;
    localparam logic [2:0] CSR_OP_RSI = 3'b110;
    localparam logic [2:0] CSR_OP_RCI = 3'b111;

    localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    typedef enum logic [1:0] {
        CSR_ST_IDLE = 2'd0,
        CSR_ST_READ = 2'd1,
        CSR_ST_EXEC = 2'd2
    } csr_state_e;

    // Immediate forms take the rs1 field itself as a zero-extended operand.
    function automatic logic csr_uses_imm(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/csr_ctrl_alu.sv
// ---------------------------------------------------------------------------
// csr_alu : combinational new-value, write-intent and bad-opcode decode
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module csr_alu
    import csr_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] op_i,
    input  logic            zero_src_i,
    output logic [XLEN-1:0] new_o,
    output logic            do_write_o,
    output logic            bad_op_o
);

    always_comb begin
        new_o      = op_i;
        do_write_o = 1'b0;
        bad_op_o   = 1'b0;
        case (funct3_i)
            CSR_OP_RW, CSR_OP_RWI: begin
                do_write_o = 1'b1;
            end
            CSR_OP_RS, CSR_OP_RSI: begin
                new_o      = old_i | op_i;
                do_write_o = !zero_src_i;
            end
            CSR_OP_RC, CSR_OP_RCI: begin
                new_o      = old_i & ~op_i;
                do_write_o = !zero_src_i;
            end
            default: begin
                bad_op_o = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/csr_ctrl.sv
// ---------------------------------------------------------------------------
// csr_ctrl : Zicsr initiator, runs read-modify-write against a registered-read
//            CSR file and returns the old value for rd writeback
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module csr_ctrl
    import csr_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        funct3_i,
    input  logic [CSR_AW-1:0] csr_addr_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [4:0]        rs1_zimm_i,
    input  logic [4:0]        rd_addr_i,
    output logic [CSR_AW-1:0] csr_raddr_o,
    input  logic [XLEN-1:0]   csr_rdata_i,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic              rd_we_o,
    output logic [4:0]        rd_waddr_o,
    output logic [XLEN-1:0]   rd_wdata_o,
    output logic              done_o,
    output logic              illegal_o,
    output logic              stall_o
);

    csr_state_e        state_q, state_d;
    logic [2:0]        funct3_q;
    logic [CSR_AW-1:0] addr_q;
    logic [XLEN-1:0]   op_q;
    logic [4:0]        zimm_q;
    logic [4:0]        rd_q;

    logic              accept;
    logic              exec;
    logic [XLEN-1:0]   new_val;
    logic              alu_write;
    logic              alu_bad;
    logic              illegal;

    logic              csr_we_q, rd_we_q, done_q, illegal_q;
    logic [CSR_AW-1:0] csr_waddr_q;
    logic [XLEN-1:0]   csr_wdata_q, rd_wdata_q;
    logic [4:0]        rd_waddr_q;

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        accept      = 1'b0;
        exec        = 1'b0;
        case (state_q)
            CSR_ST_IDLE: begin
                req_ready_o = 1'b1;
                accept      = req_valid_i;
                if (req_valid_i) state_d = CSR_ST_READ;
            end
            CSR_ST_READ: state_d = CSR_ST_EXEC;
            CSR_ST_EXEC: begin
                exec    = 1'b1;
                state_d = CSR_ST_IDLE;
            end
            default: state_d = CSR_ST_IDLE;
        endcase
        stall_o = (state_q != CSR_ST_IDLE) || accept;
    end

    csr_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .funct3_i   (funct3_q),
        .old_i      (csr_rdata_i),
        .op_i       (op_q),
        .zero_src_i (zimm_q == 5'd0),
        .new_o      (new_val),
        .do_write_o (alu_write),
        .bad_op_o   (alu_bad)
    );

    // Only an actual write into the read-only quadrant traps; pure reads are fine.
    assign illegal = alu_bad || (alu_write && (addr_q[CSR_AW-1 -: 2] == CSR_RO_PREFIX));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CSR_ST_IDLE;
            funct3_q    <= '0;
            addr_q      <= '0;
            op_q        <= '0;
            zimm_q      <= '0;
            rd_q        <= '0;
            csr_we_q    <= 1'b0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
            rd_we_q     <= 1'b0;
            rd_waddr_q  <= '0;
            rd_wdata_q  <= '0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            csr_we_q  <= exec && alu_write && !illegal;
            rd_we_q   <= exec && (rd_q != 5'd0) && !illegal;
            done_q    <= exec;
            illegal_q <= exec && illegal;
            if (accept) begin
                funct3_q <= funct3_i;
                addr_q   <= csr_addr_i;
                op_q     <= csr_uses_imm(funct3_i) ? {{(XLEN-5){1'b0}}, rs1_zimm_i}
                                                   : rs1_data_i;
                zimm_q   <= rs1_zimm_i;
                rd_q     <= rd_addr_i;
            end
            if (exec) begin
                csr_waddr_q <= addr_q;
                csr_wdata_q <= new_val;
                rd_waddr_q  <= rd_q;
                rd_wdata_q  <= csr_rdata_i;
            end
        end
    end

    assign csr_raddr_o = addr_q;
    assign csr_we_o    = csr_we_q;
    assign csr_waddr_o = csr_waddr_q;
    assign csr_wdata_o = csr_wdata_q;
    assign rd_we_o     = rd_we_q;
    assign rd_waddr_o  = rd_waddr_q;
    assign rd_wdata_o  = rd_wdata_q;
    assign done_o      = done_q;
    assign illegal_o   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_csr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_ctrl : directed self-checking bench for csr_ctrl with a CSR file model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_csr_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  funct3_i = '0;
    logic [11:0] csr_addr_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [4:0]  rs1_zimm_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic [11:0] csr_raddr_o;
    logic [31:0] csr_rdata_i = '0;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        rd_we_o;
    logic [4:0]  rd_waddr_o;
    logic [31:0] rd_wdata_o;
    logic        done_o;
    logic        illegal_o;
    logic        stall_o;

    int errors = 0;
    int checks = 0;

    // Values observed by do_op
    logic [2:0]  obs_stall;
    logic [2:0]  obs_ready;
    logic        obs_early;
    logic        o_done, o_ill, o_csr_we, o_rd_we;
    logic [11:0] o_waddr;
    logic [31:0] o_wdata, o_rd_wdata;
    logic [4:0]  o_rd_waddr;

    logic [31:0] mem [0:4095] = '{default: 32'h0};

    always #5 clk = ~clk;

    // Registered-read CSR file: data for raddr appears one cycle later.
    always @(posedge clk) begin
        csr_rdata_i <= mem[csr_raddr_o];
        if (csr_we_o) mem[csr_waddr_o] <= csr_wdata_o;
    end

    csr_ctrl #(.XLEN(32), .CSR_AW(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .funct3_i    (funct3_i),
        .csr_addr_i  (csr_addr_i),
        .rs1_data_i  (rs1_data_i),
        .rs1_zimm_i  (rs1_zimm_i),
        .rd_addr_i   (rd_addr_i),
        .csr_raddr_o (csr_raddr_o),
        .csr_rdata_i (csr_rdata_i),
        .csr_we_o    (csr_we_o),
        .csr_waddr_o (csr_waddr_o),
        .csr_wdata_o (csr_wdata_o),
        .rd_we_o     (rd_we_o),
        .rd_waddr_o  (rd_waddr_o),
        .rd_wdata_o  (rd_wdata_o),
        .done_o      (done_o),
        .illegal_o   (illegal_o),
        .stall_o     (stall_o)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents a request at the current cycle (cycle 0) and returns #1 into cycle 3.
    task automatic do_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                         input logic [4:0] z, input logic [4:0] rd, input bit hold);
        funct3_i    = f3;
        csr_addr_i  = a;
        rs1_data_i  = rs1;
        rs1_zimm_i  = z;
        rd_addr_i   = rd;
        req_valid_i = 1'b1;
        obs_early   = 1'b0;
        #1;
        obs_stall[0] = stall_o;
        obs_ready[0] = req_ready_o;
        for (int c = 1; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (!hold) req_valid_i = 1'b0;
            #1;
            obs_stall[c] = stall_o;
            obs_ready[c] = req_ready_o;
            obs_early    = obs_early | done_o | csr_we_o | rd_we_o | illegal_o;
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid_i = 1'b0;
        o_done     = done_o;
        o_ill      = illegal_o;
        o_csr_we   = csr_we_o;
        o_rd_we    = rd_we_o;
        o_waddr    = csr_waddr_o;
        o_wdata    = csr_wdata_o;
        o_rd_waddr = rd_waddr_o;
        o_rd_wdata = rd_wdata_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        checks++; if ({done_o, csr_we_o, rd_we_o, illegal_o} !== 4'b0) begin errors++; $display("FAIL reset_pulses got=%b exp=0000", {done_o, csr_we_o, rd_we_o, illegal_o}); end
        checks++; if (csr_raddr_o !== 12'h0) begin errors++; $display("FAIL reset_raddr got=%h exp=000", csr_raddr_o); end
        rst = 1'b0;
    endtask

    task automatic test_rw();
        do_op(3'b001, 12'h340, 32'hDEADBEEF, 5'd1, 5'd5, 1'b0);
        checks++; if (obs_stall !== 3'b111) begin errors++; $display("FAIL rw_stall got=%b exp=111", obs_stall); end
        checks++; if (obs_ready !== 3'b001) begin errors++; $display("FAIL rw_ready got=%b exp=001", obs_ready); end
        checks++; if (obs_early !== 1'b0) begin errors++; $display("FAIL rw_early_pulse got=%b exp=0", obs_early); end
        checks++; if (o_done !== 1'b1 || o_ill !== 1'b0) begin errors++; $display("FAIL rw_done_ill got=%b%b exp=10", o_done, o_ill); end
        checks++; if (o_rd_we !== 1'b1 || o_rd_waddr !== 5'd5 || o_rd_wdata !== 32'h0) begin errors++; $display("FAIL rw_rd got we=%b a=%0d d=%h exp we=1 a=5 d=0", o_rd_we, o_rd_waddr, o_rd_wdata); end
        checks++; if (o_csr_we !== 1'b1 || o_waddr !== 12'h340 || o_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_csr got we=%b a=%h d=%h exp we=1 a=340 d=deadbeef", o_csr_we, o_waddr, o_wdata); end
        do_op(3'b010, 12'h340, 32'h12345678, 5'd0, 5'd1, 1'b0);
        checks++; if (obs_early !== 1'b0) begin errors++; $display("FAIL rs_read_prev_pulse got=%b exp=0", obs_early); end
        checks++; if (o_rd_wdata !== 32'hDEADBEEF || o_csr_we !== 1'b0) begin errors++; $display("FAIL rs_read got d=%h we=%b exp d=deadbeef we=0", o_rd_wdata, o_csr_we); end
    endtask

    task automatic test_imm();
        do_op(3'b110, 12'h300, 32'hFFFFFFFF, 5'd8, 5'd2, 1'b0);
        checks++; if (o_csr_we !== 1'b1 || o_wdata !== 32'h8 || o_rd_wdata !== 32'h0) begin errors++; $display("FAIL rsi got we=%b w=%h rd=%h exp we=1 w=8 rd=0", o_csr_we, o_wdata, o_rd_wdata); end
        do_op(3'b111, 12'h300, 32'hFFFFFFFF, 5'd8, 5'd2, 1'b0);
        checks++; if (o_csr_we !== 1'b1 || o_wdata !== 32'h0 || o_rd_wdata !== 32'h8) begin errors++; $display("FAIL rci got we=%b w=%h rd=%h exp we=1 w=0 rd=8", o_csr_we, o_wdata, o_rd_wdata); end
    endtask

    task automatic test_ro();
        do_op(3'b010, 12'hF14, 32'hFFFFFFFF, 5'd0, 5'd3, 1'b0);
        checks++; if (o_csr_we !== 1'b0 || o_ill !== 1'b0 || o_rd_we !== 1'b1 || o_rd_wdata !== 32'h0) begin errors++; $display("FAIL ro_read got we=%b ill=%b rdwe=%b rd=%h exp 0 0 1 0", o_csr_we, o_ill, o_rd_we, o_rd_wdata); end
        do_op(3'b001, 12'hF14, 32'h1, 5'd1, 5'd4, 1'b0);
        checks++; if (o_ill !== 1'b1 || o_csr_we !== 1'b0 || o_rd_we !== 1'b0 || o_done !== 1'b1) begin errors++; $display("FAIL ro_write got ill=%b we=%b rdwe=%b done=%b exp 1 0 0 1", o_ill, o_csr_we, o_rd_we, o_done); end
    endtask

    task automatic test_bad_op();
        do_op(3'b100, 12'h340, 32'h77, 5'd1, 5'd6, 1'b0);
        checks++; if (o_ill !== 1'b1 || o_csr_we !== 1'b0 || o_rd_we !== 1'b0 || o_done !== 1'b1) begin errors++; $display("FAIL bad_op got ill=%b we=%b rdwe=%b done=%b exp 1 0 0 1", o_ill, o_csr_we, o_rd_we, o_done); end
        do_op(3'b010, 12'h340, 32'h0, 5'd0, 5'd7, 1'b0);
        checks++; if (obs_ready !== 3'b001 || obs_stall !== 3'b111) begin errors++; $display("FAIL bad_op_next_accept got rdy=%b stall=%b exp 001 111", obs_ready, obs_stall); end
        checks++; if (o_rd_wdata !== 32'hDEADBEEF || o_rd_waddr !== 5'd7) begin errors++; $display("FAIL bad_op_no_write got d=%h a=%0d exp deadbeef 7", o_rd_wdata, o_rd_waddr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] first_rd;
        logic [2:0]  first_stall;
        do_op(3'b001, 12'h341, 32'h100, 5'd1, 5'd8, 1'b1);
        first_rd    = o_rd_wdata;
        first_stall = obs_stall;
        do_op(3'b001, 12'h341, 32'h200, 5'd1, 5'd9, 1'b1);
        req_valid_i = 1'b0;
        checks++; if (first_rd !== 32'h0 || first_stall !== 3'b111) begin errors++; $display("FAIL b2b_first got rd=%h stall=%b exp 0 111", first_rd, first_stall); end
        checks++; if (obs_ready !== 3'b001 || obs_stall !== 3'b111) begin errors++; $display("FAIL b2b_second_timing got rdy=%b stall=%b exp 001 111", obs_ready, obs_stall); end
        checks++; if (o_rd_wdata !== 32'h100 || o_wdata !== 32'h200 || o_rd_waddr !== 5'd9) begin errors++; $display("FAIL b2b_second got rd=%h w=%h a=%0d exp 100 200 9", o_rd_wdata, o_wdata, o_rd_waddr); end
        do_op(3'b010, 12'h341, 32'h0, 5'd0, 5'd1, 1'b0);
        checks++; if (o_rd_wdata !== 32'h200) begin errors++; $display("FAIL b2b_readback got=%h exp=200", o_rd_wdata); end
    endtask

    task automatic test_reset_exec();
        funct3_i    = 3'b001;
        csr_addr_i  = 12'h340;
        rs1_data_i  = 32'h55;
        rs1_zimm_i  = 5'd1;
        rd_addr_i   = 5'd10;
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({done_o, csr_we_o, rd_we_o, illegal_o} !== 4'b0) begin errors++; $display("FAIL rst_exec_pulses got=%b exp=0000", {done_o, csr_we_o, rd_we_o, illegal_o}); end
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_exec_ready got=%b exp=1", req_ready_o); end
        rst = 1'b0;
        do_op(3'b010, 12'h340, 32'h0, 5'd0, 5'd1, 1'b0);
        checks++; if (o_rd_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_exec_readback got=%h exp=deadbeef", o_rd_wdata); end
    endtask

    initial begin
        test_reset();
        test_rw();
        test_imm();
        test_ro();
        test_bad_op();
        test_back_to_back();
        test_reset_exec();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
